tdm_demux4: RTL

//  Receive end of the 4-slot time-division link built around the HC153 4:1 mux.
//  The transmitter steps the mux select through slots 0..3 and marks slot 0 with sync.

---
 rtl/tdm_demux4.sv | 123 ++++++++++++
 1 files changed

// File: rtl/tdm_demux4.sv
// Receive side of a 4-slot TDM link: tracks slot position from the sync marker,
// de-interleaves slots into four channel registers and publishes whole frames atomically.
module tdm_demux4 #(
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_n,
    input  logic          sync,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] q0,
    output logic [DW-1:0] q1,
    output logic [DW-1:0] q2,
    output logic [DW-1:0] q3,
    output logic          frame_valid,
    output logic          sync_err,
    output logic          locked,
    output logic [1:0]    slot
);

    typedef enum logic {HUNT, RUN} state_t;

    state_t        state, state_nx;
    logic [1:0]    slot_nx;
    logic [DW-1:0] sh0, sh1, sh2;
    logic [DW-1:0] sh0_nx, sh1_nx, sh2_nx;
    logic          load_q, fv_nx, err_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HUNT;
            slot        <= 2'd0;
            sh0         <= '0;
            sh1         <= '0;
            sh2         <= '0;
            q0          <= '0;
            q1          <= '0;
            q2          <= '0;
            q3          <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state       <= state_nx;
            slot        <= slot_nx;
            sh0         <= sh0_nx;
            sh1         <= sh1_nx;
            sh2         <= sh2_nx;
            frame_valid <= fv_nx;
            sync_err    <= err_nx;
            // slot-3 data goes straight to q3 so all four channels change on one edge
            if (load_q) begin
                q0 <= sh0;
                q1 <= sh1;
                q2 <= sh2;
                q3 <= din;
            end
        end
    end

    always_comb begin
        state_nx = state;
        slot_nx  = slot;
        sh0_nx   = sh0;
        sh1_nx   = sh1;
        sh2_nx   = sh2;
        load_q   = 1'b0;
        fv_nx    = 1'b0;
        err_nx   = 1'b0;
        if (en_n) begin
            state_nx = HUNT;
            slot_nx  = 2'd0;
            sh0_nx   = '0;
            sh1_nx   = '0;
            sh2_nx   = '0;
        end else begin
            case (state)
                HUNT: begin
                    if (sync) begin
                        sh0_nx   = din;
                        slot_nx  = 2'd1;
                        state_nx = RUN;
                    end
                end
                RUN: begin
                    if (sync) begin
                        // sync anywhere but slot 0 re-aligns on this cycle's data
                        err_nx  = (slot != 2'd0);
                        sh0_nx  = din;
                        slot_nx = 2'd1;
                    end else begin
                        case (slot)
                            2'd0: begin
                                err_nx   = 1'b1;
                                state_nx = HUNT;
                                slot_nx  = 2'd0;
                            end
                            2'd1: begin
                                sh1_nx  = din;
                                slot_nx = 2'd2;
                            end
                            2'd2: begin
                                sh2_nx  = din;
                                slot_nx = 2'd3;
                            end
                            default: begin
                                load_q  = 1'b1;
                                fv_nx   = 1'b1;
                                slot_nx = 2'd0;
                            end
                        endcase
                    end
                end
                default: begin
                    state_nx = HUNT;
                    slot_nx  = 2'd0;
                end
            endcase
        end
    end

    assign locked = (state == RUN);

endmodule
